amp_trig_multi: RTL and testbench

Multi-channel amplifier trigger generator for the FONT5 front end. It detects the leading edge of the asynchronous machine trigger and runs a coarse delay timebase while the trigger stays high. It then issues one programmable-width pulse per enabled channel at that channel's programmed coarse delay. Each channel latches its configuration at the trigger edge and reports a missed trigger when the gate closes before its delay expires.

---
 rtl/amp_trig_pkg.sv | 16 +
 rtl/amp_trig_chan.sv | 93 +++++++++
 rtl/amp_trig_multi.sv | 109 ++++++++++
 tb/tb_amp_trig_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/amp_trig_pkg.sv
// Shared types and default sizing for the multi-channel amplifier trigger generator.
package amp_trig_pkg;

  localparam int unsigned N_CH_DEF     = 4;
  localparam int unsigned DLY_W_DEF    = 7;
  localparam int unsigned PW_W_DEF     = 4;
  localparam int unsigned BLK_SIZE_DEF = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } chan_state_e;

endpackage

// File: rtl/amp_trig_chan.sv
// One trigger channel: shadow config latched at the gate edge, delay match, pulse stretcher.
module amp_trig_chan
  import amp_trig_pkg::*;
#(
  parameter int unsigned DLY_W = DLY_W_DEF,
  parameter int unsigned PW_W  = PW_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_det,
  input  logic             trig_b,
  input  logic [DLY_W-1:0] mstr_ctr,
  input  logic             cfg_en,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [PW_W-1:0]  cfg_width,
  output logic             amp_trig,
  output logic             missed,
  output logic             active_c
);

  chan_state_e      state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [PW_W-1:0]  wid_q, wid_d;
  logic [PW_W-1:0]  wcnt_q, wcnt_d;
  logic             amp_q, amp_d;
  logic             missed_q, missed_d;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    wid_d    = wid_q;
    wcnt_d   = wcnt_q;
    amp_d    = amp_q;
    missed_d = 1'b0;

    if (edge_det) begin
      dly_d = cfg_delay;
      wid_d = cfg_width;
    end

    unique case (state_q)
      IDLE: begin
        if (edge_det && cfg_en) state_d = ARMED;
      end
      ARMED: begin
        if (mstr_ctr == dly_q) begin
          state_d = PULSE;
          wcnt_d  = wid_q;
          amp_d   = 1'b1;
        end else if (!trig_b) begin
          // A gate that re-opens in the same cycle re-arms with the fresh config.
          missed_d = 1'b1;
          state_d  = (edge_det && cfg_en) ? ARMED : IDLE;
        end
      end
      PULSE: begin
        if (wcnt_q == '0) begin
          amp_d   = 1'b0;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q - PW_W'(1);
        end
      end
      DONE: begin
        if (!trig_b) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      wid_q    <= '0;
      wcnt_q   <= '0;
      amp_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      wid_q    <= wid_d;
      wcnt_q   <= wcnt_d;
      amp_q    <= amp_d;
      missed_q <= missed_d;
    end
  end

  assign amp_trig = amp_q;
  assign missed   = missed_q;
  assign active_c = (state_q != IDLE);

endmodule

// File: rtl/amp_trig_multi.sv
// Top: trigger synchroniser, config staging, coarse timebase and per-channel trigger FSMs.
module amp_trig_multi
  import amp_trig_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEF,
  parameter int unsigned DLY_W    = DLY_W_DEF,
  parameter int unsigned PW_W     = PW_W_DEF,
  parameter int unsigned BLK_SIZE = BLK_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger_in,
  input  logic [N_CH-1:0]       trig_out_en,
  input  logic [N_CH*DLY_W-1:0] trig_out_delay,
  input  logic [N_CH*PW_W-1:0]  trig_out_width,
  output logic [N_CH-1:0]       amp_trig,
  output logic [N_CH-1:0]       missed,
  output logic                  busy
);

  localparam int unsigned BLK_W = $clog2(BLK_SIZE + 1);
  localparam logic [DLY_W-1:0] MSTR_MAX = '1;

  logic                  trig_a_q, trig_a_d, trig_b_q, trig_b_d;
  logic                  init_q, init_d, arm_q, arm_d;
  logic [N_CH-1:0]       en_r1_q, en_r2_q;
  logic [N_CH*DLY_W-1:0] dly_r1_q, dly_r2_q;
  logic [N_CH*PW_W-1:0]  wid_r1_q, wid_r2_q;
  logic [BLK_W-1:0]      blk_ctr_q, blk_ctr_d;
  logic [DLY_W-1:0]      mstr_ctr_q, mstr_ctr_d;
  logic                  edge_c;
  logic [N_CH-1:0]       active_c;

  // Edges are only honoured once the gate has been seen low after reset.
  always_comb begin
    trig_a_d = trigger_in;
    trig_b_d = trig_a_q;
    init_d   = 1'b1;
    arm_d    = arm_q | (init_q & ~trig_a_q);
    edge_c   = trig_a_q & ~trig_b_q & arm_q;
  end

  // Coarse timebase runs only while the synchronised gate is open.
  always_comb begin
    blk_ctr_d  = '0;
    mstr_ctr_d = '0;
    if (trig_b_q) begin
      if (blk_ctr_q == BLK_W'(BLK_SIZE)) begin
        blk_ctr_d  = '0;
        mstr_ctr_d = (mstr_ctr_q == MSTR_MAX) ? mstr_ctr_q : mstr_ctr_q + DLY_W'(1);
      end else begin
        blk_ctr_d  = blk_ctr_q + BLK_W'(1);
        mstr_ctr_d = mstr_ctr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_a_q   <= 1'b0;
      trig_b_q   <= 1'b0;
      init_q     <= 1'b0;
      arm_q      <= 1'b0;
      en_r1_q    <= '0;
      en_r2_q    <= '0;
      dly_r1_q   <= '0;
      dly_r2_q   <= '0;
      wid_r1_q   <= '0;
      wid_r2_q   <= '0;
      blk_ctr_q  <= '0;
      mstr_ctr_q <= '0;
    end else begin
      trig_a_q   <= trig_a_d;
      trig_b_q   <= trig_b_d;
      init_q     <= init_d;
      arm_q      <= arm_d;
      en_r1_q    <= trig_out_en;
      en_r2_q    <= en_r1_q;
      dly_r1_q   <= trig_out_delay;
      dly_r2_q   <= dly_r1_q;
      wid_r1_q   <= trig_out_width;
      wid_r2_q   <= wid_r1_q;
      blk_ctr_q  <= blk_ctr_d;
      mstr_ctr_q <= mstr_ctr_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    amp_trig_chan #(
      .DLY_W(DLY_W),
      .PW_W (PW_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .edge_det (edge_c),
      .trig_b   (trig_b_q),
      .mstr_ctr (mstr_ctr_q),
      .cfg_en   (en_r2_q[k]),
      .cfg_delay(dly_r2_q[k*DLY_W +: DLY_W]),
      .cfg_width(wid_r2_q[k*PW_W +: PW_W]),
      .amp_trig (amp_trig[k]),
      .missed   (missed[k]),
      .active_c (active_c[k])
    );
  end

  assign busy = |active_c;

endmodule

// File: tb/tb_amp_trig_multi.sv
// Scoreboard bench for amp_trig_multi: expected pulses/missed strobes queued by stimulus, matched by a monitor.
module tb_amp_trig_multi;

  localparam int N_CH  = 4;
  localparam int DLY_W = 7;
  localparam int PW_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  trigger_in;
  logic [N_CH-1:0]       trig_out_en;
  logic [N_CH*DLY_W-1:0] trig_out_delay;
  logic [N_CH*PW_W-1:0]  trig_out_width;
  logic [N_CH-1:0]       amp_trig;
  logic [N_CH-1:0]       missed;
  logic                  busy;

  amp_trig_multi #(.N_CH(N_CH), .DLY_W(DLY_W), .PW_W(PW_W), .BLK_SIZE(20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger_in    (trigger_in),
    .trig_out_en   (trig_out_en),
    .trig_out_delay(trig_out_delay),
    .trig_out_width(trig_out_width),
    .amp_trig      (amp_trig),
    .missed        (missed),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_miss;
    int ch;
    int start;
    int len;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_pulse(input int ch, input int start, input int len);
    exp_t e;
    e.is_miss = 1'b0; e.ch = ch; e.start = start; e.len = len;
    sb_q.push_back(e);
  endtask

  task automatic push_missed(input int ch, input int at);
    exp_t e;
    e.is_miss = 1'b1; e.ch = ch; e.start = at; e.len = 0;
    sb_q.push_back(e);
  endtask

  task automatic match(input bit is_miss, input int ch, input int start, input int len);
    int idx = -1;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (idx < 0 && sb_q[i].is_miss == is_miss && sb_q[i].ch == ch) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s ch%0d at cycle %0d len %0d", is_miss ? "missed" : "pulse", ch, start, len);
    end else begin
      if (sb_q[idx].start != start || sb_q[idx].len != len) begin
        errors++;
        $display("FAIL %s_ch%0d: got start %0d len %0d, expected start %0d len %0d",
                 is_miss ? "missed" : "pulse", ch, start, len, sb_q[idx].start, sb_q[idx].len);
      end
      sb_q.delete(idx);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: reconstruct each pulse (start cycle, length) and each missed strobe.
  int prev [N_CH];
  int st   [N_CH];
  int ln   [N_CH];
  initial for (int k = 0; k < N_CH; k++) begin prev[k] = 0; st[k] = 0; ln[k] = 0; end

  always @(negedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (amp_trig[k]) begin
        if (prev[k] == 0) begin st[k] = cyc; ln[k] = 1; end
        else ln[k] = ln[k] + 1;
      end else if (prev[k] != 0) begin
        match(1'b0, k, st[k], ln[k]);
      end
      if (missed[k]) match(1'b1, k, cyc, 0);
      prev[k] = amp_trig[k] ? 1 : 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int k, input bit en, input int d, input int w);
    trig_out_en[k]                   = en;
    trig_out_delay[k*DLY_W +: DLY_W] = DLY_W'(d);
    trig_out_width[k*PW_W +: PW_W]   = PW_W'(w);
  endtask

  int r, l;

  initial begin
    rst_n = 1'b0; trigger_in = 1'b0;
    trig_out_en = '0; trig_out_delay = '0; trig_out_width = '0;
    tick(3);
    chk("rst_amp_trig", int'(amp_trig), 0);
    chk("rst_missed", int'(missed), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(5);

    // Single channel, zero delay, one-cycle pulse.
    set_cfg(0, 1, 0, 0);
    tick(5);
    r = cyc; push_pulse(0, r + 3, 1);
    trigger_in = 1'b1; tick(20); trigger_in = 1'b0; tick(10);
    chk("t1_busy_idle", int'(busy), 0);

    // Four channels, mixed delays and widths.
    set_cfg(0, 1, 1, 0); set_cfg(1, 1, 2, 3); set_cfg(2, 1, 3, 7); set_cfg(3, 1, 5, 15);
    tick(5);
    r = cyc;
    push_pulse(0, r + 24, 1); push_pulse(1, r + 45, 4);
    push_pulse(2, r + 66, 8); push_pulse(3, r + 108, 16);
    trigger_in = 1'b1; tick(50);
    chk("t2_busy_active", int'(busy), 1);
    tick(80); trigger_in = 1'b0; tick(10);
    chk("t2_busy_idle", int'(busy), 0);
    chk("t2_amp_idle", int'(amp_trig), 0);

    // Gate closes before delay expires.
    set_cfg(0, 1, 10, 0); set_cfg(1, 0, 0, 0); set_cfg(2, 0, 0, 0); set_cfg(3, 0, 0, 0);
    tick(5);
    trigger_in = 1'b1; tick(50);
    chk("t3_busy_armed", int'(busy), 1);
    tick(50);
    l = cyc; push_missed(0, l + 3);
    trigger_in = 1'b0; tick(10);
    chk("t3_busy_idle", int'(busy), 0);

    // Maximum delay reached through master counter saturation.
    set_cfg(0, 1, 127, 2);
    tick(5);
    r = cyc; push_pulse(0, r + 3 + 127 * 21, 3);
    trigger_in = 1'b1; tick(2700);
    chk("t4_mstr_sat_a", int'(dut.mstr_ctr_q), 127);
    tick(400);
    chk("t4_mstr_sat_b", int'(dut.mstr_ctr_q), 127);
    chk("t4_busy_done", int'(busy), 1);
    trigger_in = 1'b0; tick(10);
    chk("t4_busy_idle", int'(busy), 0);

    // Config changed mid-gate, plus a second edge while ch0 is pulsing.
    set_cfg(0, 1, 1, 5); set_cfg(1, 0, 0, 0);
    tick(5);
    r = cyc; push_pulse(0, r + 24, 6);
    trigger_in = 1'b1; tick(10);
    set_cfg(0, 1, 2, 1); set_cfg(1, 1, 0, 0);
    tick(14);
    trigger_in = 1'b0; tick(2);
    push_pulse(1, r + 29, 1);
    trigger_in = 1'b1; tick(34);
    trigger_in = 1'b0; tick(10);
    chk("t5_busy_idle", int'(busy), 0);
    r = cyc; push_pulse(0, r + 45, 2); push_pulse(1, r + 3, 1);
    trigger_in = 1'b1; tick(60); trigger_in = 1'b0; tick(10);

    // Reset during a pulse; gate held high through release must not retrigger.
    set_cfg(0, 1, 0, 15); set_cfg(1, 0, 0, 0);
    tick(5);
    r = cyc; push_pulse(0, r + 3, 3);
    trigger_in = 1'b1; tick(6);
    rst_n = 1'b0; #1;
    chk("t6_amp_async_clear", int'(amp_trig), 0);
    chk("t6_busy_in_reset", int'(busy), 0);
    tick(3); rst_n = 1'b1; tick(50);
    chk("t6_no_pulse_after_release", int'(amp_trig), 0);
    chk("t6_busy_after_release", int'(busy), 0);
    trigger_in = 1'b0; tick(5);
    r = cyc; push_pulse(0, r + 3, 16);
    trigger_in = 1'b1; tick(30); trigger_in = 1'b0; tick(10);

    chk("sb_leftover", sb_q.size(), 0);
    for (int i = 0; i < sb_q.size(); i++)
      $display("FAIL sb_missing_ch%0d: no event seen, expected start %0d len %0d",
               sb_q[i].ch, sb_q[i].start, sb_q[i].len);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
